// File: rtl/fsm_pkg.sv
// -----------------------------------------------------------------------------
// fsm_pkg
// Shared definitions for the fsm_seq_det serial pattern detector:
//   - state_t : FSM state encoding (S_IDLE / S_RUN / S_HOLD)
//   - CNT_W   : width of the optional hit counter
//   - sat_inc : saturating increment used by the hit counter
// No ports (package).
// -----------------------------------------------------------------------------
package fsm_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,  // no valid bit since reset or clr
    S_RUN  = 2'b01,  // collecting bits
    S_HOLD = 2'b10   // detect reported, hold timer running
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fsm_seq_det_if.sv
// -----------------------------------------------------------------------------
// fsm_seq_det_if
// Bundles the serial input and the detector outputs of fsm_seq_det.
//   in_valid  : in_bit is sampled this cycle
//   in_bit    : serial data bit
//   x         : Mealy detect output (combinational)
//   y         : Moore hold output (registered)
//   dbg_state : current FSM state, for observation only
//   hit_cnt   : saturating hit count, present only with FSM_SEQ_DET_CNT_EN
// Handshake: a bit is consumed on every rising clk edge where in_valid=1;
// there is no back-pressure, the detector always accepts.
// Modports: master drives the serial input, slave is the detector.
// -----------------------------------------------------------------------------
interface fsm_seq_det_if #(
  parameter int DW = 8
);
  import fsm_pkg::*;

  logic          in_valid;
  logic          in_bit;
  logic [DW-1:0] x;
  logic [DW-1:0] y;
  state_t        dbg_state;
`ifdef FSM_SEQ_DET_CNT_EN
  logic [CNT_W-1:0] hit_cnt;

  modport master (output in_valid, output in_bit,
                  input x, input y, input dbg_state, input hit_cnt);
  modport slave  (input in_valid, input in_bit,
                  output x, output y, output dbg_state, output hit_cnt);
`else
  modport master (output in_valid, output in_bit,
                  input x, input y, input dbg_state);
  modport slave  (input in_valid, input in_bit,
                  output x, output y, output dbg_state);
`endif

endinterface

// File: rtl/fsm_seq_hist.sv
// -----------------------------------------------------------------------------
// fsm_seq_hist
// Bit history, fill counter and pattern compare for fsm_seq_det.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : synchronous clear of history and fill
//   in_valid_i  : in_bit_i is sampled this cycle
//   in_bit_i    : serial data bit
//   hit_o       : the current valid bit completes the pattern (combinational)
// -----------------------------------------------------------------------------
module fsm_seq_hist #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 OVERLAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic in_valid_i,
  input  logic in_bit_i,
  output logic hit_o
);

  // fill never exceeds PAT_LEN-1, which always fits in $clog2(PAT_LEN) bits.
  localparam int            FW   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PAT_LEN-1:0] window;
  logic               full;

  // Oldest bit in the MSB, the bit arriving now in the LSB.
  assign window = {hist_q, in_bit_i};
  assign full   = (fill_q == FULL);
  assign hit_o  = in_valid_i && !clr_i && full && (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid_i) begin
      hist_d = window[PAT_LEN-2:0];
      // Non-overlapping: a hit discards the history so the next detect
      // needs PAT_LEN fresh bits. Overlapping: fill stays saturated.
      if (hit_o && (OVERLAP == 0)) begin
        fill_d = '0;
      end else if (!full) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/fsm_seq_det.sv
// -----------------------------------------------------------------------------
// fsm_seq_det
// Serial pattern detector with a Mealy detect output and a Moore hold output.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear of state, history and counters
//   bus    : fsm_seq_det_if.slave (in_valid, in_bit, x, y, dbg_state, hit_cnt)
// x = OUT_VAL in the cycle a valid bit completes PATTERN, else 0.
// y = OUT_VAL for HOLD_CYC cycles after the most recent hit, else 0.
// Optional feature macro: FSM_SEQ_DET_CNT_EN adds the saturating hit_cnt.
// -----------------------------------------------------------------------------
module fsm_seq_det
  import fsm_pkg::*;
#(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1011,
  parameter int                 DW       = 8,
  parameter logic [DW-1:0]      OUT_VAL  = 8'd168,
  parameter int                 HOLD_CYC = 3,
  parameter int                 OVERLAP  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  fsm_seq_det_if.slave bus
);

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("fsm_seq_det: PAT_LEN must be in 2..16");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold_cyc
    $error("fsm_seq_det: HOLD_CYC must be in 1..255");
  end
  if (OVERLAP != 0 && OVERLAP != 1) begin : g_bad_overlap
    $error("fsm_seq_det: OVERLAP must be 0 or 1");
  end
  if (DW < 1) begin : g_bad_dw
    $error("fsm_seq_det: DW must be at least 1");
  end

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);

  logic          hit;
  state_t        state_q;
  logic [7:0]    hold_cnt_q;
  logic [DW-1:0] y_q;

  fsm_seq_hist #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_hist (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .in_valid_i (bus.in_valid),
    .in_bit_i   (bus.in_bit),
    .hit_o      (hit)
  );

  // y is registered alongside the state so it is high exactly while the
  // FSM sits in S_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      y_q        <= '0;
    end else if (clr) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      y_q        <= '0;
    end else if (hit) begin
      // A hit in S_HOLD restarts the hold window.
      state_q    <= S_HOLD;
      hold_cnt_q <= HOLD_LOAD;
      y_q        <= OUT_VAL;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) state_q <= S_RUN;
        end
        S_RUN: begin
          state_q <= S_RUN;
        end
        S_HOLD: begin
          if (hold_cnt_q != 8'd0) begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
          end else begin
            state_q <= S_RUN;
            y_q     <= '0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          hold_cnt_q <= '0;
          y_q        <= '0;
        end
      endcase
    end
  end

`ifdef FSM_SEQ_DET_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
    end else if (clr) begin
      hit_cnt_q <= '0;
    end else if (hit) begin
      hit_cnt_q <= sat_inc(hit_cnt_q);
    end
  end

  assign bus.hit_cnt = hit_cnt_q;
`endif

  // hit is already suppressed by clr, so x drops in the clr cycle.
  assign bus.x         = hit ? OUT_VAL : '0;
  assign bus.y         = y_q;
  assign bus.dbg_state = state_q;

endmodule
